// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, types and modular helpers for the NTT core.
//   Q / DW / AW        modulus, coefficient width, RAM address width
//   BARRETT_K/M        Barrett reduction shift and multiplier
//   BFLY_PER_NTT       butterflies in one full transform (N/2 * log2 N)
//   addMod / subMod    (x +/- y) mod Q for operands already < Q
package ntt_pkg;

  localparam int Q            = 3329;
  localparam int DW           = 12;
  localparam int AW           = 8;
  localparam int N            = 1 << AW;
  localparam int BARRETT_K    = 2 * DW;
  localparam int BARRETT_M    = 5039;
  localparam int BFLY_PER_NTT = N / 2 * AW;
  localparam int CNT_W        = $clog2(BFLY_PER_NTT);
  localparam int LAT          = 4;

  typedef logic [DW-1:0]   coeff_t;
  typedef logic [AW-1:0]   addr_t;
  typedef logic [2*DW-1:0] prod_t;

  localparam logic [DW:0] QX = (DW+1)'(Q);

  // One conditional subtract is enough because x + y < 2Q.
  function automatic coeff_t addMod(input coeff_t x, input coeff_t y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return coeff_t'((s >= QX) ? s - QX : s);
  endfunction

  // Borrow out of the extended subtract marks a negative difference.
  function automatic coeff_t subMod(input coeff_t x, input coeff_t y);
    logic [DW:0] d;
    d = {1'b0, x} - {1'b0, y};
    return coeff_t'(d[DW] ? d + QX : d);
  endfunction

endpackage

// File: rtl/ntt_mod_mult.sv
// ntt_mod_mult: (x * y) mod Q, two register stages.
//   clk, rst   clock, async active-high reset
//   ldProd     load the raw product register (stage S2)
//   ldRes      load the reduced result register (stage S3)
//   x, y       operands, expected < Q
//   res        reduced product, < Q
module ntt_mod_mult
  import ntt_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ldProd,
  input  logic   ldRes,
  input  coeff_t x,
  input  coeff_t y,
  output coeff_t res
);

  // Wide enough for prod * BARRETT_M without overflow.
  localparam int XW = 2 * DW + $clog2(BARRETT_M + 1);

  prod_t         prod;
  logic [XW-1:0] pm, t, r;

  always_ff @(posedge clk or posedge rst)
    if (rst)         prod <= '0;
    else if (ldProd) prod <= prod_t'(x) * prod_t'(y);

  // Quotient estimate undershoots by at most one, so r < 2Q.
  always_comb begin
    pm = XW'(prod) * XW'(BARRETT_M);
    t  = pm >> BARRETT_K;
    r  = XW'(prod) - t * XW'(Q);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)        res <= '0;
    else if (ldRes) res <= coeff_t'((r >= XW'(Q)) ? r - XW'(Q) : r);

endmodule

// File: rtl/ntt_butterfly_unit.sv
// ntt_butterfly_unit: 4-stage pipelined modular butterfly for the NTT core.
//   clk, rst                 clock, async active-high reset
//   in_valid                 operands valid this cycle (no backpressure)
//   in_a, in_b, in_w         coefficients and twiddle, < Q
//   in_addr_a, in_addr_b     write-back addresses, delayed to match data
//   inverse                  (NTT_BFLY_GS_EN only) 1 = Gentleman-Sande
//   out_valid                result valid / RAM write strobe
//   out_a, out_b             results
//   out_addr_a, out_addr_b   aligned write-back addresses
//   ntt_done                 pulse with the last butterfly of a transform
// Build option: define NTT_BFLY_GS_EN to add the inverse (GS) butterfly.
// CT: S1 reg, S2/S3 b*w mod Q, S4 a +/- r.
// GS: S1 a+b and a-b, S2/S3 (a-b)*w mod Q, S4 pass-through.
module ntt_butterfly_unit
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_w,
  input  logic [AW-1:0] in_addr_a,
  input  logic [AW-1:0] in_addr_b,
`ifdef NTT_BFLY_GS_EN
  input  logic          inverse,
`endif
  output logic          out_valid,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [AW-1:0] out_addr_a,
  output logic [AW-1:0] out_addr_b,
  output logic          ntt_done
);

  localparam int STAGES = LAT;

  logic [STAGES:1]        vldPipe;
  logic [STAGES-1:1]      invPipe;
  addr_t [STAGES:1]       addrAPipe, addrBPipe;
  coeff_t                 aS1, bS1, wS1, aS2, aS3, rS3, outA, outB;
  logic [CNT_W-1:0]       bflyCnt;
  logic                   doneReg;
  logic                   invIn;

`ifdef NTT_BFLY_GS_EN
  assign invIn = inverse;
`else
  assign invIn = 1'b0;
`endif

  // Valid and mode bits: free-running shift, cleared by reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vldPipe <= '0;
      invPipe <= '0;
    end else begin
      vldPipe <= {vldPipe[STAGES-1:1], in_valid};
      invPipe <= {invPipe[STAGES-2:1], invIn};
    end

  // Address delay line; each stage loads only when its data stage loads.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addrAPipe <= '0;
      addrBPipe <= '0;
    end else begin
      if (in_valid) begin
        addrAPipe[1] <= in_addr_a;
        addrBPipe[1] <= in_addr_b;
      end
      for (int s = 2; s <= STAGES; s++)
        if (vldPipe[s-1]) begin
          addrAPipe[s] <= addrAPipe[s-1];
          addrBPipe[s] <= addrBPipe[s-1];
        end
    end

  // S1: capture operands; GS folds its add/sub in here.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      aS1 <= '0;
      bS1 <= '0;
      wS1 <= '0;
    end else if (in_valid) begin
      aS1 <= invIn ? addMod(in_a, in_b) : in_a;
      bS1 <= invIn ? subMod(in_a, in_b) : in_b;
      wS1 <= in_w;
    end

  // S2/S3: multiplier operand is bS1 in both modes.
  ntt_mod_mult uMult (
    .clk    (clk),
    .rst    (rst),
    .ldProd (vldPipe[1]),
    .ldRes  (vldPipe[2]),
    .x      (bS1),
    .y      (wS1),
    .res    (rS3)
  );

  // Carry the a operand alongside the multiplier.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      aS2 <= '0;
      aS3 <= '0;
    end else begin
      if (vldPipe[1]) aS2 <= aS1;
      if (vldPipe[2]) aS3 <= aS2;
    end

  // S4: CT add/sub, GS pass-through.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      outA <= '0;
      outB <= '0;
    end else if (vldPipe[3]) begin
      outA <= invPipe[3] ? aS3 : addMod(aS3, rS3);
      outB <= invPipe[3] ? rS3 : subMod(aS3, rS3);
    end

  // Counter advances with each result leaving S4; the done flag is
  // registered with that same result so both appear in one cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bflyCnt <= '0;
      doneReg <= 1'b0;
    end else if (vldPipe[3]) begin
      bflyCnt <= bflyCnt + 1'b1;
      doneReg <= (bflyCnt == CNT_W'(BFLY_PER_NTT - 1));
    end else begin
      doneReg <= 1'b0;
    end

  assign out_valid  = vldPipe[STAGES];
  assign out_a      = outA;
  assign out_b      = outB;
  assign out_addr_a = addrAPipe[STAGES];
  assign out_addr_b = addrBPipe[STAGES];
  assign ntt_done   = doneReg;

endmodule
